jm_done_arbiter: RTL and testbench

- Completion-side scheduler between the KERNEL_NUM engines and the job completion writer.
- Tracks each kernel as idle, running or done-pending, and latches a job tag at start and a return code at done.
- Arbitrates pending completions round-robin onto the single complete_push/complete_ready stream.
- Each transfer carries return_data = {tag, code}.

---
 rtl/jm_pkg.sv | 18 +
 rtl/jm_done_arbiter_if.sv | 21 ++
 rtl/jm_rr_arbiter.sv | 34 +++
 rtl/jm_done_arbiter.sv | 178 +++++++++++++++++
 tb/tb_jm_done_arbiter.sv | 271 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/jm_pkg.sv
// Shared types and helpers for the kernel completion arbiter.
// Kernel state encoding, the timeout return code and the index-width helper.
package jm_pkg;

  typedef enum logic [1:0] {
    K_IDLE = 2'b00,
    K_RUN  = 2'b01,
    K_PEND = 2'b10
  } kstate_t;

  // Wide enough for any CODE_WIDTH up to 64; callers truncate to their width.
  localparam logic [63:0] TIMEOUT_CODE = '1;

  function automatic int idx_w(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/jm_done_arbiter_if.sv
// Completion stream from the arbiter to the completion writer.
// Valid/ready: data and index hold while push is high and ready is low.
interface jm_done_arbiter_if #(
  parameter int RETURN_WIDTH = 41,
  parameter int IDX_W        = 1
);
  logic                    complete_push_o;
  logic [RETURN_WIDTH-1:0] return_data_o;
  logic [IDX_W-1:0]        grant_kernel_o;
  logic                    complete_ready_i;

  modport master (
    output complete_push_o, return_data_o, grant_kernel_o,
    input  complete_ready_i
  );

  modport slave (
    input  complete_push_o, return_data_o, grant_kernel_o,
    output complete_ready_i
  );
endinterface

// File: rtl/jm_rr_arbiter.sv
// Round-robin picker: first set request at or after ptr_i, wrapping.
// Purely combinational; the pointer register lives in the parent.
module jm_rr_arbiter #(
  parameter int N  = 2,
  parameter int IW = 1
) (
  input  logic [N-1:0]  req_i,
  input  logic [IW-1:0] ptr_i,
  output logic [N-1:0]  gnt_o,
  output logic [IW-1:0] idx_o,
  output logic          vld_o
);

  always_comb begin
    int          j;
    logic [IW-1:0] jj;
    gnt_o = '0;
    idx_o = '0;
    vld_o = 1'b0;
    j     = 0;
    jj    = '0;
    for (int i = 0; i < N; i++) begin
      j = int'(ptr_i) + i;
      if (j >= N) j = j - N;
      jj = IW'(j);
      if (!vld_o && req_i[jj]) begin
        vld_o     = 1'b1;
        gnt_o[jj] = 1'b1;
        idx_o     = jj;
      end
    end
  end

endmodule

// File: rtl/jm_done_arbiter.sv
// Per-kernel idle/run/pend tracking with round-robin completion push; done->push in 2 cycles.
// Output register reloads only when empty or transferring. JM_DONE_TIMEOUT_EN adds a RUN watchdog.
module jm_done_arbiter
  import jm_pkg::*;
#(
  parameter int KERNEL_NUM     = 2,
  parameter int RETURN_WIDTH   = 41,
  parameter int CODE_WIDTH     = 32,
  parameter int TAG_WIDTH      = RETURN_WIDTH - CODE_WIDTH,
  parameter int TIMEOUT_CYCLES = 2**20
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [KERNEL_NUM-1:0]          engine_start_i,
  input  logic [TAG_WIDTH-1:0]           start_tag_i,
  input  logic [KERNEL_NUM-1:0]          engine_done_i,
  input  logic [KERNEL_NUM*CODE_WIDTH-1:0] return_code_i,
  jm_done_arbiter_if.master              cpl,
  output logic [KERNEL_NUM-1:0]          kernel_busy_o,
  output logic                           err_o,
  input  logic                           err_clr_i
);

  localparam int IW = idx_w(KERNEL_NUM);

  if (KERNEL_NUM < 1 || KERNEL_NUM > 16 || TIMEOUT_CYCLES < 2 || CODE_WIDTH > 64 ||
      TAG_WIDTH + CODE_WIDTH != RETURN_WIDTH) begin : g_bad_param
    $error("jm_done_arbiter: unsupported parameter combination");
  end

  kstate_t                 state_q [KERNEL_NUM];
  kstate_t                 state_d [KERNEL_NUM];
  logic [TAG_WIDTH-1:0]    tag_q   [KERNEL_NUM];
  logic [TAG_WIDTH-1:0]    tag_d   [KERNEL_NUM];
  logic [CODE_WIDTH-1:0]   code_q  [KERNEL_NUM];
  logic [CODE_WIDTH-1:0]   code_d  [KERNEL_NUM];
  logic [KERNEL_NUM-1:0]   busy_q, busy_d;
  logic                    push_q, push_d;
  logic [RETURN_WIDTH-1:0] data_q, data_d;
  logic [IW-1:0]           grant_q, grant_d;
  logic [IW-1:0]           ptr_q, ptr_d;
  logic                    err_q, err_d;

`ifdef JM_DONE_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES);
  logic [CW-1:0]           cnt_q [KERNEL_NUM];
  logic [CW-1:0]           cnt_d [KERNEL_NUM];
`endif

  logic [KERNEL_NUM-1:0]   pend_req;
  logic [KERNEL_NUM-1:0]   rr_gnt;
  logic [IW-1:0]           rr_idx;
  logic                    rr_vld;

  always_comb begin
    for (int k = 0; k < KERNEL_NUM; k++) pend_req[k] = (state_q[k] == K_PEND);
  end

  jm_rr_arbiter #(.N(KERNEL_NUM), .IW(IW)) u_rr (
    .req_i (pend_req),
    .ptr_i (ptr_q),
    .gnt_o (rr_gnt),
    .idx_o (rr_idx),
    .vld_o (rr_vld)
  );

  always_comb begin
    logic start_multi;
    logic free;
    logic load;
    logic err_set;

    state_d = state_q;
    tag_d   = tag_q;
    code_d  = code_q;
    busy_d  = '0;
    push_d  = push_q;
    data_d  = data_q;
    grant_d = grant_q;
    ptr_d   = ptr_q;
`ifdef JM_DONE_TIMEOUT_EN
    cnt_d   = cnt_q;
`endif

    start_multi = !$onehot0(engine_start_i);
    free        = !push_q || cpl.complete_ready_i;
    load        = free && rr_vld;
    err_set     = start_multi;

    for (int k = 0; k < KERNEL_NUM; k++) begin
      if (engine_start_i[k] && !start_multi) begin
        if (state_q[k] == K_IDLE) begin
          state_d[k] = K_RUN;
          tag_d[k]   = start_tag_i;
`ifdef JM_DONE_TIMEOUT_EN
          cnt_d[k]   = '0;
`endif
        end else begin
          err_set = 1'b1;
        end
      end

      if (engine_done_i[k]) begin
        if (state_q[k] == K_RUN) begin
          state_d[k] = K_PEND;
          code_d[k]  = return_code_i[k*CODE_WIDTH +: CODE_WIDTH];
        end else begin
          err_set = 1'b1;
        end
      end
`ifdef JM_DONE_TIMEOUT_EN
      else if (state_q[k] == K_RUN) begin
        if (cnt_q[k] == CW'(TIMEOUT_CYCLES - 1)) begin
          state_d[k] = K_PEND;
          code_d[k]  = CODE_WIDTH'(TIMEOUT_CODE);
          err_set    = 1'b1;
        end else begin
          cnt_d[k] = cnt_q[k] + CW'(1);
        end
      end
`endif

      // Only a PEND kernel can be granted, so this never collides with start/done.
      if (load && rr_gnt[k]) state_d[k] = K_IDLE;
      busy_d[k] = (state_d[k] != K_IDLE);
    end

    if (free) push_d = rr_vld;
    if (load) begin
      data_d  = RETURN_WIDTH'({tag_q[rr_idx], code_q[rr_idx]});
      grant_d = rr_idx;
      ptr_d   = (int'(rr_idx) == KERNEL_NUM - 1) ? '0 : rr_idx + IW'(1);
    end

    err_d = err_set | (err_q & ~err_clr_i);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < KERNEL_NUM; k++) begin
        state_q[k] <= K_IDLE;
        tag_q[k]   <= '0;
        code_q[k]  <= '0;
`ifdef JM_DONE_TIMEOUT_EN
        cnt_q[k]   <= '0;
`endif
      end
      busy_q  <= '0;
      push_q  <= 1'b0;
      data_q  <= '0;
      grant_q <= '0;
      ptr_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      for (int k = 0; k < KERNEL_NUM; k++) begin
        state_q[k] <= state_d[k];
        tag_q[k]   <= tag_d[k];
        code_q[k]  <= code_d[k];
`ifdef JM_DONE_TIMEOUT_EN
        cnt_q[k]   <= cnt_d[k];
`endif
      end
      busy_q  <= busy_d;
      push_q  <= push_d;
      data_q  <= data_d;
      grant_q <= grant_d;
      ptr_q   <= ptr_d;
      err_q   <= err_d;
    end
  end

  assign cpl.complete_push_o = push_q;
  assign cpl.return_data_o   = data_q;
  assign cpl.grant_kernel_o  = grant_q;
  assign kernel_busy_o       = busy_q;
  assign err_o               = err_q;

endmodule

// File: tb/tb_jm_done_arbiter.sv
// Bench for jm_done_arbiter: directed scenarios plus random traffic against a queue-free
// behavioural model of the kernel lifecycle and round-robin completion order.
module tb_jm_done_arbiter;
  localparam int K  = 2;
  localparam int CW = 32;
  localparam int TW = 9;
  localparam int RW = 41;
  localparam int TO = 16;

  logic            clk;
  logic            rst;
  logic [K-1:0]    engine_start;
  logic [TW-1:0]   start_tag;
  logic [K-1:0]    engine_done;
  logic [K*CW-1:0] return_code;
  logic [K-1:0]    kernel_busy;
  logic            err;
  logic            err_clr;

  jm_done_arbiter_if #(.RETURN_WIDTH(RW), .IDX_W(1)) cif ();

  jm_done_arbiter #(
    .KERNEL_NUM(K), .RETURN_WIDTH(RW), .CODE_WIDTH(CW), .TAG_WIDTH(TW), .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk(clk), .rst(rst),
    .engine_start_i(engine_start), .start_tag_i(start_tag),
    .engine_done_i(engine_done), .return_code_i(return_code),
    .cpl(cif),
    .kernel_busy_o(kernel_busy), .err_o(err), .err_clr_i(err_clr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  // Model: kernel life stage 0=idle 1=running 2=awaiting completion.
  int          m_st   [K];
  logic [TW-1:0] m_tag [K];
  logic [CW-1:0] m_code[K];
  int          m_age  [K];
  bit          m_push;
  logic [RW-1:0] m_data;
  int          m_grant;
  int          m_ptr;
  bit          m_err;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < K; k++) begin
      m_st[k] = 0; m_tag[k] = '0; m_code[k] = '0; m_age[k] = 0;
    end
    m_push = 0; m_data = '0; m_grant = 0; m_ptr = 0; m_err = 0;
  endtask

  task automatic model_step();
    int nst[K];
    int w;
    bit free;
    bit eset;
    eset = 0;
    free = !m_push || cif.complete_ready_i;
    w = -1;
    for (int i = 0; i < K; i++) begin
      int j;
      j = (m_ptr + i) % K;
      if (w < 0 && m_st[j] == 2) w = j;
    end
    nst = m_st;
    if ($countones(engine_start) > 1) eset = 1;
    else begin
      for (int k = 0; k < K; k++)
        if (engine_start[k]) begin
          if (m_st[k] == 0) begin nst[k] = 1; m_tag[k] = start_tag; m_age[k] = 0; end
          else eset = 1;
        end
    end
    for (int k = 0; k < K; k++) begin
      if (engine_done[k]) begin
        if (m_st[k] == 1) begin nst[k] = 2; m_code[k] = return_code[k*CW +: CW]; end
        else eset = 1;
      end
`ifdef JM_DONE_TIMEOUT_EN
      else if (m_st[k] == 1) begin
        if (m_age[k] == TO - 1) begin nst[k] = 2; m_code[k] = '1; eset = 1; end
        else m_age[k]++;
      end
`endif
    end
    if (free) begin
      if (w >= 0) begin
        m_push = 1; m_data = {m_tag[w], m_code[w]}; m_grant = w;
        nst[w] = 0; m_ptr = (w + 1) % K;
      end else m_push = 0;
    end
    m_st = nst;
    if (eset) m_err = 1;
    else if (err_clr) m_err = 0;
  endtask

  task automatic model_cmp();
    logic [K-1:0] b;
    for (int k = 0; k < K; k++) b[k] = (m_st[k] != 0);
    chk("model_push", 64'(cif.complete_push_o), 64'(m_push));
    if (m_push) begin
      chk("model_data", 64'(cif.return_data_o), 64'(m_data));
      chk("model_grant", 64'(cif.grant_kernel_o), 64'(m_grant));
    end
    chk("model_busy", 64'(kernel_busy), 64'(b));
    chk("model_err", 64'(err), 64'(m_err));
  endtask

  task automatic step();
    @(posedge clk);
    model_step();
    @(negedge clk);
    model_cmp();
  endtask

  task automatic clr_in();
    engine_start = '0; engine_done = '0; err_clr = 1'b0;
  endtask

  initial begin
    #500us;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    logic [RW-1:0] held;
    rst = 1'b1; clr_in(); start_tag = '0; return_code = '0; cif.complete_ready_i = 1'b1;
    model_reset();
    repeat (2) @(negedge clk);
    chk("rst_push", 64'(cif.complete_push_o), 64'd0);
    chk("rst_data", 64'(cif.return_data_o), 64'd0);
    chk("rst_grant", 64'(cif.grant_kernel_o), 64'd0);
    chk("rst_busy", 64'(kernel_busy), 64'd0);
    chk("rst_err", 64'(err), 64'd0);
    rst = 1'b0;

    // Single job on kernel 0
    engine_start = 2'b01; start_tag = 9'h05A; step(); clr_in();
    chk("t1_busy_run", 64'(kernel_busy), 64'b01);
    repeat (3) step();
    engine_done = 2'b01; return_code[31:0] = 32'h0000_0001; step(); clr_in();
    chk("t1_pend_nopush", 64'(cif.complete_push_o), 64'd0);
    step();
    chk("t1_push", 64'(cif.complete_push_o), 64'd1);
    chk("t1_data", 64'(cif.return_data_o), 64'({9'h05A, 32'h0000_0001}));
    chk("t1_grant", 64'(cif.grant_kernel_o), 64'd0);
    step();
    chk("t1_idle_busy", 64'(kernel_busy), 64'd0);
    chk("t1_drop", 64'(cif.complete_push_o), 64'd0);

    // Simultaneous done, pointer now at 1
    engine_start = 2'b01; start_tag = 9'h033; step(); clr_in();
    engine_start = 2'b10; start_tag = 9'h1B1; step(); clr_in();
    engine_done = 2'b11; return_code = {32'h0000_00B1, 32'h0000_00A0}; step(); clr_in();
    step();
    chk("t2_first_grant", 64'(cif.grant_kernel_o), 64'd1);
    chk("t2_first_data", 64'(cif.return_data_o), 64'({9'h1B1, 32'h0000_00B1}));
    step();
    chk("t2_second_push", 64'(cif.complete_push_o), 64'd1);
    chk("t2_second_grant", 64'(cif.grant_kernel_o), 64'd0);
    chk("t2_second_data", 64'(cif.return_data_o), 64'({9'h033, 32'h0000_00A0}));
    step();
    chk("t2_drain", 64'(cif.complete_push_o), 64'd0);

    // Backpressure: k1 held 20 cycles while k0 completes
    engine_start = 2'b10; start_tag = 9'h0C3; step(); clr_in();
    engine_start = 2'b01; start_tag = 9'h044; step(); clr_in();
    engine_done = 2'b10; return_code = {32'h11, 32'h0}; step(); clr_in();
    cif.complete_ready_i = 1'b0; step();
    chk("t3_push", 64'(cif.complete_push_o), 64'd1);
    held = cif.return_data_o;
    for (int i = 0; i < 20; i++) begin
      if (i == 5) begin engine_done = 2'b01; return_code = {32'h0, 32'h22}; end
      step(); clr_in();
      chk("t3_hold_data", 64'(cif.return_data_o), 64'({9'h0C3, 32'h11}));
      chk("t3_hold_grant", 64'(cif.grant_kernel_o), 64'd1);
    end
    chk("t3_held_first", 64'(held), 64'({9'h0C3, 32'h11}));
    cif.complete_ready_i = 1'b1; step();
    chk("t3_next_grant", 64'(cif.grant_kernel_o), 64'd0);
    chk("t3_next_data", 64'(cif.return_data_o), 64'({9'h044, 32'h22}));
    step();

    // Protocol errors
    engine_start = 2'b10; start_tag = 9'h0AA; step(); clr_in();
    chk("t4_no_err", 64'(err), 64'd0);
    engine_start = 2'b10; start_tag = 9'h155; step(); clr_in();
    chk("t4_busy_start_err", 64'(err), 64'd1);
    err_clr = 1'b1; step(); clr_in();
    chk("t4_clr", 64'(err), 64'd0);
    engine_done = 2'b01; step(); clr_in();
    chk("t4_idle_done_err", 64'(err), 64'd1);
    step();
    chk("t4_no_push", 64'(cif.complete_push_o), 64'd0);
    engine_done = 2'b10; return_code = {32'h77, 32'h0}; err_clr = 1'b1; step(); clr_in();
    step();
    chk("t4_tag_kept", 64'(cif.return_data_o), 64'({9'h0AA, 32'h77}));
    step();

    // Reset mid-operation
    engine_start = 2'b01; start_tag = 9'h011; step(); clr_in();
    engine_start = 2'b10; start_tag = 9'h022; step(); clr_in();
    engine_done = 2'b11; step(); clr_in();
    cif.complete_ready_i = 1'b0; step();
    chk("t5_pre_push", 64'(cif.complete_push_o), 64'd1);
    #2 rst = 1'b1; model_reset();
    #1;
    chk("t5_async_push", 64'(cif.complete_push_o), 64'd0);
    chk("t5_async_busy", 64'(kernel_busy), 64'd0);
    @(negedge clk); rst = 1'b0; cif.complete_ready_i = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("t5_no_cpl", 64'(cif.complete_push_o), 64'd0);
    end

`ifdef JM_DONE_TIMEOUT_EN
    engine_start = 2'b01; start_tag = 9'h0EE; step(); clr_in();
    n = 0;
    while (!cif.complete_push_o && n < 40) begin step(); n++; end
    chk("to_latency", 64'(n), 64'd17);
    chk("to_data", 64'(cif.return_data_o), 64'({9'h0EE, 32'hFFFF_FFFF}));
    chk("to_err", 64'(err), 64'd1);
    err_clr = 1'b1; step(); clr_in();
`endif

    // Random traffic
    for (int c = 0; c < 3000; c++) begin
      int r;
      clr_in();
      r = $urandom_range(0, 99);
      if (r < 40) begin
        int k;
        k = $urandom_range(0, K - 1);
        if (r < 30) for (int i = 0; i < K; i++) if (m_st[i] == 0) k = i;
        engine_start[k] = 1'b1;
        start_tag = TW'($urandom);
      end else if (r < 44) begin
        engine_start = '1;
      end
      for (int k = 0; k < K; k++) engine_done[k] = ($urandom_range(0, 3) == 0);
      return_code = {$urandom, $urandom};
      cif.complete_ready_i = ($urandom_range(0, 9) < 7);
      err_clr = ($urandom_range(0, 15) == 0);
      if ($urandom_range(0, 399) == 0) begin
        #2 rst = 1'b1; model_reset();
        #1 chk("rnd_rst_push", 64'(cif.complete_push_o), 64'd0);
        @(negedge clk); rst = 1'b0;
      end
      step();
    end
    clr_in();

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
